// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M/RV64M multiply/divide unit. It sits beside the ALU and
//   decodes M-extension R-type instructions. Multiplies use radix-2 shift-add
//   and divides use restoring division. Both run on operand magnitudes, one
//   bit per cycle, and fix up the sign at the end. The core is stalled while
//   an operation is in flight. The writeback mux takes `result` while `done`
//   is high.
//
// Parameters
//   XLEN   operand/result width (32 or 64)
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   synchronous active-low reset, aborts any operation
//   start   in   instruction present in decode/execute this cycle
//   alu_op  in   main-decoder ALU op (2'b10 = R-type)
//   funct3  in   instruction funct3 (operation select)
//   funct7  in   instruction funct7 (7'b0000001 = M extension)
//   rs1     in   operand A (multiplicand / dividend)
//   rs2     in   operand B (multiplier / divisor)
//   is_m    out  combinational M-extension decode
//   stall   out  combinational pipeline hold
//   busy    out  registered, unit not idle
//   done    out  registered one-cycle result-valid pulse
//   result  out  registered result, held until the next accepted operation
//
// Optional feature
//   MULDIV_EARLY_OUT_EN: multiplies stop after max(1, bit length of the
//   multiplier magnitude) iterations instead of XLEN.
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            is_m,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int               CNT_W     = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0]  MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;     // product, or remainder in the low half
  logic [2*XLEN-1:0]   mc_q, mc_d;       // shifting multiplicand, or divisor
  logic [XLEN-1:0]     mp_q, mp_d;       // shifting multiplier, or dividend/quotient
  logic [XLEN-1:0]     result_q, result_d;
  logic                neg_q, neg_d;     // negate product / quotient
  logic                rneg_q, rneg_d;   // negate remainder
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    last_q, last_d;   // iteration index that finishes the op

  logic                accept;
  logic                s1, s2, neg1, neg2, div0, ovf;
  logic [XLEN-1:0]     mag1, mag2;
  logic [CNT_W-1:0]    mul_last;

  logic [2*XLEN-1:0]   acc_m, prod;
  logic [XLEN:0]       r_sh;
  logic                r_ge;
  logic [XLEN-1:0]     r_new, q_new, fin_div, fin_mul;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v,
                                               input logic            neg);
    return neg ? -v : v;
  endfunction

  assign is_m   = (alu_op == 2'b10) && (funct7 == 7'b0000001);
  assign accept = (state_q == IDLE) && start && is_m;
  assign stall  = accept || (state_q == CALC);
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

  // Operand decode at accept: signedness, magnitudes and special cases.
  always_comb begin
    s1 = 1'b0;
    s2 = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        s1 = 1'b1;
        s2 = 1'b1;
      end
      3'b010:  s1 = 1'b1;
      default: ;
    endcase
    neg1 = s1 & rs1[XLEN-1];
    neg2 = s2 & rs2[XLEN-1];
    mag1 = cond_neg(rs1, neg1);
    mag2 = cond_neg(rs2, neg2);
    div0 = funct3[2] && (rs2 == '0);
    ovf  = funct3[2] && !funct3[0] && (rs1 == MOST_NEG) && (rs2 == '1);
  end

`ifdef MULDIV_EARLY_OUT_EN
  function automatic logic [CNT_W-1:0] bit_len(input logic [XLEN-1:0] v);
    bit_len = '0;
    for (int i = 0; i < XLEN; i++) begin
      if (v[i]) bit_len = CNT_W'(i + 1);
    end
  endfunction

  logic [CNT_W-1:0] mul_len;
  assign mul_len  = bit_len(mag2);
  assign mul_last = (mul_len == '0) ? '0 : mul_len - CNT_W'(1);
`else
  assign mul_last = LAST_FULL;
`endif

  // One iteration of each algorithm, plus the sign fix-up for the last one.
  always_comb begin
    acc_m   = mp_q[0] ? (acc_q + mc_q) : acc_q;
    prod    = neg_q ? -acc_m : acc_m;
    r_sh    = {acc_q[XLEN-1:0], mp_q[XLEN-1]};
    r_ge    = r_sh >= {1'b0, mc_q[XLEN-1:0]};
    // The true difference is below the divisor, so XLEN bits are exact.
    r_new   = r_ge ? (r_sh[XLEN-1:0] - mc_q[XLEN-1:0]) : r_sh[XLEN-1:0];
    q_new   = {mp_q[XLEN-2:0], r_ge};
    fin_div = op_q[1] ? cond_neg(r_new, rneg_q) : cond_neg(q_new, neg_q);
    fin_mul = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    mc_d     = mc_q;
    mp_d     = mp_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d   = funct3;
          neg_d  = neg1 ^ neg2;
          rneg_d = neg1;
          cnt_d  = '0;
          acc_d  = '0;
          if (funct3[2]) begin
            mc_d   = {{XLEN{1'b0}}, mag2};
            mp_d   = mag1;
            last_d = LAST_FULL;
          end else begin
            mc_d   = {{XLEN{1'b0}}, mag1};
            mp_d   = mag2;
            last_d = mul_last;
          end
          if (div0) begin
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = funct3[1] ? rs1 : '1;
          end else if (ovf) begin
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = funct3[1] ? '0 : MOST_NEG;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (op_q[2]) begin
          acc_d = {{XLEN{1'b0}}, r_new};
          mp_d  = q_new;
        end else begin
          acc_d = acc_m;
          mc_d  = mc_q << 1;
          mp_d  = mp_q >> 1;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == last_q) begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = op_q[2] ? fin_div : fin_mul;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      acc_q    <= '0;
      mc_q     <= '0;
      mp_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      cnt_q    <= '0;
      last_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      mc_q     <= mc_d;
      mp_q     <= mp_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Self-checking bench for muldiv_unit (XLEN = 32). Expected results and
//   latencies come from a behavioural model and are queued when an operation
//   is started. They are popped and compared when done rises.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      alu_op = 2'b00;
  logic [2:0]      funct3 = 3'b000;
  logic [6:0]      funct7 = 7'b0;
  logic [XLEN-1:0] rs1 = '0;
  logic [XLEN-1:0] rs2 = '0;
  logic            is_m, stall, busy, done;
  logic [XLEN-1:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_res_q[$];
  int          exp_lat_q[$];

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .alu_op (alu_op),
    .funct3 (funct3),
    .funct7 (funct7),
    .rs1    (rs1),
    .rs2    (rs2),
    .is_m   (is_m),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_res(input logic [2:0] f3,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ubl;
    logic [63:0] p;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ubl = {32'b0, b};
    case (f3)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ubl; return p[63:32]; end
      3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb;
        return p[31:0];
      end
      3'b101: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'b110: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb;
        return p[31:0];
      end
      default: begin
        if (b == 32'h0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f3,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
    logic [31:0] mag;
    int          n;
    if (f3[2]) begin
      if (b == 32'h0) return 1;
      if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
`ifdef MULDIV_EARLY_OUT_EN
    mag = ((f3 == 3'b000 || f3 == 3'b001) && b[31]) ? (~b + 32'd1) : b;
    n = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) n = i + 1;
    if (n == 0) n = 1;
    return n + 1;
`else
    mag = a ^ b;
    n = (mag == 32'h0) ? 33 : 33;
    return n;
`endif
  endfunction

  task automatic drive_m(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b);
    alu_op = 2'b10;
    funct7 = 7'b0000001;
    funct3 = f3;
    rs1    = a;
    rs2    = b;
    start  = 1'b1;
  endtask

  // Start one operation, optionally poke a spurious start at CALC cycle
  // poke_at, then wait for done and check result, latency and stall.
  task automatic run_op(input string name, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input int poke_at);
    int          lat, stall_hi, el;
    logic        st_now;
    logic [31:0] er;
    @(posedge clk); #1;
    drive_m(f3, a, b);
    exp_res_q.push_back(model_res(f3, a, b));
    exp_lat_q.push_back(model_lat(f3, a, b));
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin
      n_bad++;
      $display("FAIL %s stall_start got=%b want=1", name, stall);
    end
    stall_hi = 1;
    lat      = 0;
    st_now   = 1'b0;
    do begin
      @(posedge clk); #1;
      lat++;
      st_now = stall;
      if (done !== 1'b1 && stall === 1'b1) stall_hi++;
      if (lat == poke_at) begin
        start  = 1'b1;
        funct3 = 3'b000;
      end else begin
        start = 1'b0;
      end
      rs1 = $urandom;
      rs2 = $urandom;
    end while (done !== 1'b1 && lat < 200);
    start = 1'b0;
    er = exp_res_q.pop_front();
    el = exp_lat_q.pop_front();
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL %s done_timeout got=%0d cycles want=%0d", name, lat, el);
    end
    n_cmp++;
    if (result !== er) begin
      n_bad++;
      $display("FAIL %s result got=%h want=%h", name, result, er);
    end
    n_cmp++;
    if (lat !== el) begin
      n_bad++;
      $display("FAIL %s latency got=%0d want=%0d", name, lat, el);
    end
    n_cmp++;
    if (st_now !== 1'b0) begin
      n_bad++;
      $display("FAIL %s stall_at_done got=%b want=0", name, st_now);
    end
    n_cmp++;
    if (stall_hi !== el) begin
      n_bad++;
      $display("FAIL %s stall_cycles got=%0d want=%0d", name, stall_hi, el);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
    n_cmp++;
    if (result !== 32'h0) begin n_bad++; $display("FAIL reset_result got=%h want=0", result); end
    n_cmp++;
    if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b want=0", stall); end
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    run_op("mul_7_m3", 3'b000, 32'd7, 32'hFFFF_FFFD, -1);
  endtask

  task automatic test_mul_high();
    run_op("mulh_min_min", 3'b001, 32'h8000_0000, 32'h8000_0000, -1);
    run_op("mulhu_ones", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_op("mulhsu_ones", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
  endtask

  task automatic test_divide();
    run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, -1);
    run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, -1);
    run_op("divu_100_7", 3'b101, 32'd100, 32'd7, -1);
    run_op("remu_100_7", 3'b111, 32'd100, 32'd7, -1);
  endtask

  task automatic test_special();
    run_op("div_by_zero", 3'b100, 32'd5, 32'd0, -1);
    run_op("remu_by_zero", 3'b111, 32'd5, 32'd0, -1);
    run_op("div_overflow", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op("rem_overflow", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, -1);
  endtask

  task automatic test_ignored();
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      alu_op = (k == 0) ? 2'b10 : 2'b00;
      funct7 = (k == 0) ? 7'b0 : 7'b0000001;
      funct3 = 3'b000;
      rs1    = 32'd5;
      rs2    = 32'd6;
      start  = 1'b1;
      #1;
      n_cmp++;
      if (is_m !== 1'b0) begin n_bad++; $display("FAIL ignored%0d_is_m got=%b want=0", k, is_m); end
      n_cmp++;
      if (stall !== 1'b0) begin n_bad++; $display("FAIL ignored%0d_stall got=%b want=0", k, stall); end
      @(posedge clk); #1;
      start = 1'b0;
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL ignored%0d_busy got=%b want=0", k, busy); end
    end
  endtask

  task automatic test_start_during_calc();
    run_op("divu_poke", 3'b101, 32'd100, 32'd7, 6);
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL poke_idle_busy got=%b want=0", busy); end
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL poke_idle_done got=%b want=0", done); end
  endtask

  task automatic test_reset_midop();
    logic seen;
    @(posedge clk); #1;
    drive_m(3'b101, 32'd100, 32'd7);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL midrst_busy_before got=%b want=1", busy); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done got=%b want=0", done); end
    n_cmp++;
    if (result !== 32'h0) begin n_bad++; $display("FAIL midrst_result got=%h want=0", result); end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_late_done got=%b want=0", seen); end
  endtask

  task automatic test_early_out();
    run_op("mul_3x2", 3'b000, 32'd3, 32'd2, -1);
    run_op("mul_3x0", 3'b000, 32'd3, 32'd0, -1);
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f3;
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      case (i % 4)
        0:       b = 32'h0;
        1:       b = $urandom_range(1, 20);
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      run_op($sformatf("b2b_%0d_op%0d", i, f3), f3, a, b, -1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mul();
    test_mul_high();
    test_divide();
    test_special();
    test_ignored();
    test_start_during_calc();
    test_reset_midop();
    test_early_out();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
